// File: rtl/game_state_pkg.sv
// Shared game-flow state encoding for the controller and the HUD renderer.
// Contents: STATE_W, state_e (ST_IDLE..ST_OVER).
package game_state_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_RESPAWN = 3'd3,
    ST_DEAD    = 3'd4,
    ST_OVER    = 3'd5
  } state_e;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Event/status bundle between the input logic, game_state_ctrl and the HUD.
// master: drives start/pause/resume/die, reads status; slave: the controller.
interface game_state_ctrl_if
  import game_state_pkg::*;
#(
  parameter int LIVES_W = 2,
  parameter int TICK_W  = 16
) ();

  logic               start;
  logic               pause;
  logic               resume;
  logic               die;
  logic [STATE_W-1:0] state;
  logic [LIVES_W-1:0] lives;
  logic [TICK_W-1:0]  play_ticks;
  logic               game_over;
  logic               state_chg;

  modport master (
    output start, pause, resume, die,
    input  state, lives, play_ticks,
    input  game_over, state_chg
  );

  modport slave (
    input  start, pause, resume, die,
    output state, lives, play_ticks,
    output game_over, state_chg
  );

endinterface

// File: rtl/game_state_ctrl_edge_rise.sv
// edge_rise: 1-bit rising-edge detector, history resets to 1 so a level
// held through reset release does not fire. Ports: clk, reset, x_i, ev_o.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic x_i,
  output logic ev_o
);

  logic x_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= 1'b1;
    end else begin
      x_q <= x_i;
    end
  end

  assign ev_o = x_i & ~x_q;

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: six-state game flow with lives, timed respawn, play-time
// counter. Ports: clk, reset (async, active-low), bus (slave modport).
// Optional: GAME_PAUSE_TIMEOUT_EN adds a PAUSE auto-abort to IDLE.
module game_state_ctrl
  import game_state_pkg::*;
#(
  parameter int LIVES_W       = 2,
  parameter int LIVES_INIT    = 3,
  parameter int RESPAWN_CYC   = 16,
  parameter int TICK_W        = 16,
  parameter int PAUSE_TIMEOUT = 1000
) (
  input logic         clk,
  input logic         reset,
  game_state_ctrl_if.slave bus
);

  localparam int RSP_W =
    (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
  localparam logic [RSP_W-1:0] RSP_LOAD =
    RSP_W'(RESPAWN_CYC - 1);
  localparam logic [LIVES_W-1:0] LIVES_LD =
    LIVES_W'(LIVES_INIT);

`ifdef GAME_PAUSE_TIMEOUT_EN
  localparam int PT_W =
    (PAUSE_TIMEOUT > 1) ? $clog2(PAUSE_TIMEOUT) : 1;
  localparam logic [PT_W-1:0] PT_LAST =
    PT_W'(PAUSE_TIMEOUT - 1);
  logic [PT_W-1:0] pcnt_q;
`else
  // No pause counter in this build; the parameter is only referenced here.
  logic [31:0] unused_pt;
  assign unused_pt = 32'(PAUSE_TIMEOUT);
`endif

  logic ev_start;
  logic ev_pause;
  logic ev_resume;
  logic ev_die;

  edge_rise u_start (
    .clk  (clk),
    .reset(reset),
    .x_i  (bus.start),
    .ev_o (ev_start)
  );

  edge_rise u_pause (
    .clk  (clk),
    .reset(reset),
    .x_i  (bus.pause),
    .ev_o (ev_pause)
  );

  edge_rise u_resume (
    .clk  (clk),
    .reset(reset),
    .x_i  (bus.resume),
    .ev_o (ev_resume)
  );

  edge_rise u_die (
    .clk  (clk),
    .reset(reset),
    .x_i  (bus.die),
    .ev_o (ev_die)
  );

  state_e             state_q;
  logic [LIVES_W-1:0] lives_q;
  logic [TICK_W-1:0]  ticks_q;
  logic [RSP_W-1:0]   rsp_q;
  logic               go_q;
  logic               chg_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lives_q <= '0;
      ticks_q <= '0;
      rsp_q   <= '0;
      go_q    <= 1'b0;
      chg_q   <= 1'b0;
`ifdef GAME_PAUSE_TIMEOUT_EN
      pcnt_q  <= '0;
`endif
    end else begin
      go_q  <= 1'b0;
      chg_q <= 1'b0;

      // Every cycle spent in PLAY counts, including the exit cycle.
      if (state_q == ST_PLAY && !(&ticks_q)) begin
        ticks_q <= ticks_q + TICK_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (ev_start) begin
            state_q <= ST_PLAY;
            lives_q <= LIVES_LD;
            ticks_q <= '0;
            chg_q   <= 1'b1;
          end
        end

        ST_PLAY: begin
          if (ev_die) begin
            chg_q <= 1'b1;
            if (lives_q <= LIVES_W'(1)) begin
              state_q <= ST_OVER;
              lives_q <= '0;
              go_q    <= 1'b1;
            end else begin
              state_q <= ST_RESPAWN;
              lives_q <= lives_q - LIVES_W'(1);
              rsp_q   <= RSP_LOAD;
            end
          end else if (ev_pause) begin
            state_q <= ST_PAUSE;
            chg_q   <= 1'b1;
`ifdef GAME_PAUSE_TIMEOUT_EN
            pcnt_q  <= '0;
`endif
          end
        end

        ST_PAUSE: begin
          // Resume beats a timeout expiring on the same edge.
          if (ev_resume) begin
            state_q <= ST_PLAY;
            chg_q   <= 1'b1;
          end
`ifdef GAME_PAUSE_TIMEOUT_EN
          else if (pcnt_q == PT_LAST) begin
            state_q <= ST_IDLE;
            lives_q <= '0;
            chg_q   <= 1'b1;
          end else begin
            pcnt_q <= pcnt_q + PT_W'(1);
          end
`endif
        end

        ST_RESPAWN: begin
          // Loaded with RESPAWN_CYC-1 so the phase lasts RESPAWN_CYC cycles.
          if (rsp_q == '0) begin
            state_q <= ST_PLAY;
            chg_q   <= 1'b1;
          end else begin
            rsp_q <= rsp_q - RSP_W'(1);
          end
        end

        ST_OVER: begin
          if (ev_start) begin
            state_q <= ST_PLAY;
            lives_q <= LIVES_LD;
            ticks_q <= '0;
            chg_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          chg_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.lives      = lives_q;
  assign bus.play_ticks = ticks_q;
  assign bus.game_over  = go_q;
  assign bus.state_chg  = chg_q;

endmodule
